// File: rtl/lcd_bus_sequencer.sv
// HD44780 single-write bus sequencer: setup, E pulse, hold, exec wait.
// All phase durations count one-clk enable ticks; 8- or 4-bit bus.
module lcd_bus_sequencer #(
  parameter int FOUR_BIT   = 0,
  parameter int TSU_TICKS  = 1,
  parameter int TPW_TICKS  = 1,
  parameter int TH_TICKS   = 1,
  parameter int WAIT_SHORT = 40,
  parameter int WAIT_LONG  = 1600,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  input  logic       in_nib_only,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, SETUP, EHIGH, HOLD, WAIT
  } state_e;

  localparam logic [CNT_W-1:0] TSU_L = CNT_W'(TSU_TICKS - 1);
  localparam logic [CNT_W-1:0] TPW_L = CNT_W'(TPW_TICKS - 1);
  localparam logic [CNT_W-1:0] TH_L  = CNT_W'(TH_TICKS - 1);
  localparam logic [CNT_W-1:0] WS_L  = CNT_W'(WAIT_SHORT - 1);
  localparam logic [CNT_W-1:0] WL_L  = CNT_W'(WAIT_LONG - 1);
  localparam logic             FOUR  = (FOUR_BIT != 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim_d;
  logic [7:0]       data_q;
  logic             nib_q;
  logic             idx_q;
  logic             e_q;
  logic             rs_q;
  logic [7:0]       db_q;
  logic             done_q;
  logic             long_w;

  assign long_w   = !rs_q && (data_q[7:2] == 6'b0);
  assign in_ready = rst && (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_db   = db_q;
  assign lcd_rw   = 1'b0;

  // Last counter value of the current phase.
  always_comb begin
    lim_d = '0;
    case (state_q)
      SETUP:   lim_d = TSU_L;
      EHIGH:   lim_d = TPW_L;
      HOLD:    lim_d = TH_L;
      WAIT:    lim_d = long_w ? WL_L : WS_L;
      default: lim_d = '0;
    endcase
  end

  // Phase sequencer with registered pin drives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      nib_q   <= 1'b0;
      idx_q   <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (in_valid && in_ready) begin
          data_q  <= in_data;
          nib_q   <= FOUR && in_nib_only;
          rs_q    <= in_rs;
          db_q    <= FOUR ? {in_data[7:4], 4'b0} : in_data;
          cnt_q   <= '0;
          state_q <= SETUP;
        end
      end else if (tick) begin
        if (cnt_q == lim_d) begin
          cnt_q <= '0;
          case (state_q)
            SETUP: begin
              e_q     <= 1'b1;
              state_q <= EHIGH;
            end
            EHIGH: begin
              e_q     <= 1'b0;
              state_q <= HOLD;
            end
            HOLD: begin
              if (FOUR && !idx_q && !nib_q) begin
                db_q    <= {data_q[3:0], 4'b0};
                idx_q   <= 1'b1;
                state_q <= SETUP;
              end else begin
                state_q <= WAIT;
              end
            end
            WAIT: begin
              idx_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
Sequences single HD44780 bus write transactions (command or data) onto the LCD pins. It enforces setup, enable pulse width, hold and post-write execution delay. All timing is counted in enable ticks, supplied as a one-clk pulse from the team's clock divider path. It sits between the LCD init/print controller (upstream, valid/ready) and the LCD pins; 8-bit or 4-bit bus mode is selected at elaboration.

Parameters:
FOUR_BIT, 0, 1 = 4-bit bus (high nibble then low nibble on db[7:4]); 0 = 8-bit bus
TSU_TICKS, 1, ticks with RS/DB stable and E low before E rises (>=1)
TPW_TICKS, 1, ticks E held high (>=1)
TH_TICKS, 1, ticks RS/DB held after E falls (>=1)
WAIT_SHORT, 40, post-write execution wait in ticks, normal commands and data (>=1)
WAIT_LONG, 1600, post-write wait in ticks for clear/home (>=1)
CNT_W, 11, timing counter width; must hold max(all tick params)-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
tick  in  1  timing enable, one clk wide; all phase durations count ticks
in_valid  in  1  upstream has a write pending
in_ready  out  1  block accepts a write this cycle
in_rs  in  1  register select: 0 command, 1 data
in_data  in  8  byte to write
in_nib_only  in  1  4-bit mode only: write high nibble only (init sequence); ignored if FOUR_BIT=0
lcd_e  out  1  enable strobe
lcd_rs  out  1  register select pin
lcd_rw  out  1  read/write pin, constant 0
lcd_db  out  8  data pins; in 4-bit mode db[3:0] driven 0
busy  out  1  high in every state except IDLE
done  out  1  one-clk pulse when a transaction completes

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, lcd_e=0, lcd_rs=0, lcd_db=0, done=0, busy=0. in_ready=0 while rst is low.
- States: IDLE, SETUP, EHIGH, HOLD, WAIT. A 1-bit nibble index tracks the 4-bit mode nibble.
- IDLE: in_ready=1. Accept on a clk edge where in_valid&in_ready. On accept:
  - Latch rs, data and nib_only.
  - Drive lcd_rs and lcd_db: 8-bit mode puts the full byte on db; 4-bit mode puts data[7:4] on db[7:4].
  - Clear the counter and enter SETUP.
- Phase timing:
  - Entering any phase clears the counter.
  - The counter increments on each clk with tick=1.
  - A phase of N ticks exits on the clk where tick=1 and counter==N-1.
  - With tick held at 1, a phase lasts exactly N clks. With tick at 0, all phases stall and outputs hold.
- SETUP (TSU_TICKS) -> EHIGH. lcd_e=1 exactly while in EHIGH.
- EHIGH (TPW_TICKS) -> HOLD.
- HOLD (TH_TICKS), with lcd_rs/lcd_db unchanged:
  - 4-bit mode, first nibble, nib_only=0: drive data[3:0] on db[7:4], set nibble index, -> SETUP.
  - Otherwise: -> WAIT.
- WAIT: lcd_db and lcd_rs hold their last values. Duration is WAIT_LONG when latched rs=0 and data[7:2]==6'b0 (clear 0x01, home 0x02/0x03); otherwise WAIT_SHORT. A command 0x00 also selects WAIT_LONG; this is intended. On exit -> IDLE, done=1 for that one cycle (registered), nibble index cleared.
- Upstream inputs are ignored outside IDLE; in_data changes mid-transaction have no effect.
- An accept is possible in the same cycle that done is high (back-to-back, no gap cycle).
- Counter never wraps, given that the CNT_W constraint is met.
- rst asserted mid-transaction: immediate return to reset values, lcd_e drops asynchronously, no done pulse.

Test Plan:
1. FOUR_BIT=0, tick=1 constant, write rs=1 data=0x41:
   - lcd_db=0x41 and lcd_rs=1 from the accept edge.
   - lcd_e high exactly 1 clk, starting 1 clk after accept.
   - busy for 43 clks; done pulses on the 43rd clk after accept; in_ready=1 the same cycle.
2. FOUR_BIT=1, tick=1, write rs=0 data=0x28:
   - db[7:4]=0x2 with one E pulse, then db[7:4]=0x8 with a second E pulse, E low between them.
   - db[3:0]=0 throughout; done 46 clks after accept.
3. FOUR_BIT=0, write rs=0 data=0x01: WAIT lasts 1600 clks. Repeat with rs=1 data=0x01: WAIT lasts 40 clks.
4. FOUR_BIT=1, in_nib_only=1, data=0x30: exactly one E pulse with db[7:4]=0x3; done 43 clks after accept.
5. tick asserted every 4th clk, FOUR_BIT=0 write:
   - E high exactly 4 clks.
   - Total busy equals 43 ticks.
   - in_valid toggled during busy produces no second transaction.
6. rst pulsed low while in EHIGH: lcd_e=0, busy=0, lcd_db=0 immediately. After release, in_ready=1 and a new write completes normally.
